// File: rtl/mem_dma_ctrl.sv
// Byte-wide DMA engine sharing one memory port with a CPU.
// The CPU always wins the port; the engine freezes for any cycle it loses it.
module mem_dma_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mode,
    input  logic [7:0] src_addr,
    input  logic [7:0] dst_addr,
    input  logic [7:0] len,
    input  logic [7:0] fill_val,
    input  logic       cpu_req,
    input  logic       cpu_wr_en,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_dat_in,
    output logic [7:0] cpu_dat_out,
    input  logic [7:0] mem_dat_out,
    output logic       mem_wr_en,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_dat_in,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {IDLE, RD, WR, FILL, DONE} state_t;

    state_t     state_reg;
    logic [7:0] src_ptr_reg;
    logic [7:0] dst_ptr_reg;
    logic [7:0] count_reg;
    logic [7:0] buf_reg;
    logic [7:0] fill_reg;
    logic       busy_reg;
    logic       done_reg;

    assign cpu_dat_out = mem_dat_out;
    assign busy        = busy_reg;
    assign done        = done_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            src_ptr_reg <= 8'h00;
            dst_ptr_reg <= 8'h00;
            count_reg   <= 8'h00;
            buf_reg     <= 8'h00;
            fill_reg    <= 8'h00;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else if (state_reg == DONE) begin
            // DONE always lasts one cycle, even if the CPU holds the port
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else if (!cpu_req) begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        src_ptr_reg <= src_addr;
                        dst_ptr_reg <= dst_addr;
                        count_reg   <= len;
                        fill_reg    <= fill_val;
                        busy_reg    <= 1'b1;
                        if (len == 8'd0) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else if (mode) begin
                            state_reg <= FILL;
                        end else begin
                            state_reg <= RD;
                        end
                    end
                end
                RD: begin
                    buf_reg   <= mem_dat_out;
                    state_reg <= WR;
                end
                WR: begin
                    src_ptr_reg <= src_ptr_reg + 8'd1;
                    dst_ptr_reg <= dst_ptr_reg + 8'd1;
                    count_reg   <= count_reg - 8'd1;
                    if (count_reg == 8'd1) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg <= RD;
                    end
                end
                FILL: begin
                    dst_ptr_reg <= dst_ptr_reg + 8'd1;
                    count_reg   <= count_reg - 8'd1;
                    if (count_reg == 8'd1) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg <= FILL;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_addr   = cpu_addr;
        mem_dat_in = cpu_dat_in;
        mem_wr_en  = cpu_req & cpu_wr_en;
        if (!cpu_req) begin
            case (state_reg)
                RD: mem_addr = src_ptr_reg;
                WR: begin
                    mem_addr   = dst_ptr_reg;
                    mem_dat_in = buf_reg;
                    mem_wr_en  = 1'b1;
                end
                FILL: begin
                    mem_addr   = dst_ptr_reg;
                    mem_dat_in = fill_reg;
                    mem_wr_en  = 1'b1;
                end
                default: ;
            endcase
            // a transfer being aborted by reset must not land one more byte
            if (!rst_n) mem_wr_en = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_dma_ctrl.sv
// Scoreboard bench for mem_dma_ctrl: expected memory writes and done pulses
// are queued by the stimulus and consumed by a negedge monitor.
module tb_mem_dma_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, start, mode, cpu_req, cpu_wr_en;
    logic [7:0] src_addr, dst_addr, len, fill_val, cpu_addr, cpu_dat_in;
    logic [7:0] cpu_dat_out, mem_dat_out, mem_addr, mem_dat_in;
    logic       mem_wr_en, busy, done;

    typedef struct { int cyc; int busy_len; } done_t;
    typedef struct { int addr; int data; } wr_t;

    done_t exp_done[$];
    wr_t   exp_wr[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int busy_run = 0;

    logic [7:0] mem [256];
    bit         mem_ready = 1'b0;

    always #5 clk = ~clk;

    mem_dma_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_val(fill_val),
        .cpu_req(cpu_req), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr),
        .cpu_dat_in(cpu_dat_in), .cpu_dat_out(cpu_dat_out), .mem_dat_out(mem_dat_out),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_dat_in(mem_dat_in),
        .busy(busy), .done(done)
    );

    // 256x8 data memory, combinational read, background pattern addr ^ 0x5A
    assign mem_dat_out = mem[mem_addr];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
            mem_ready <= 1'b1;
        end else if (mem_wr_en) begin
            mem[mem_addr] <= mem_dat_in;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: every write on the port and every done pulse is scored
    always @(negedge clk) begin
        wr_t   w;
        done_t d;
        if (busy) busy_run = busy_run + 1;
        else      busy_run = 0;
        if (mem_wr_en) begin
            if (exp_wr.size() == 0) begin
                check("unexpected_write_addr", int'(mem_addr), -1);
            end else begin
                w = exp_wr.pop_front();
                check("write_addr", int'(mem_addr), w.addr);
                check("write_data", int'(mem_dat_in), w.data);
                $display("write mem[%02h] <= %02h", mem_addr, mem_dat_in);
            end
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            if (exp_done.size() == 0) begin
                check("unexpected_done_cycle", cyc, -1);
            end else begin
                d = exp_done.pop_front();
                check("done_cycle", cyc, d.cyc);
                check("busy_cycles", busy_run, d.busy_len);
                $display("done at cycle %0d after %0d busy cycles", cyc, busy_run);
            end
        end
    end

    // Called just after a posedge; the start edge is the next posedge.
    task automatic go(input logic m, input logic [7:0] s, input logic [7:0] d,
                      input logic [7:0] l, input logic [7:0] f,
                      input int lat, input int ncyc_busy);
        done_t e;
        e.cyc      = cyc + 1 + lat - 1;
        e.busy_len = ncyc_busy;
        exp_done.push_back(e);
        start = 1'b1; mode = m; src_addr = s; dst_addr = d; len = l; fill_val = f;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic expect_wr(input int a, input int dv);
        wr_t w;
        w.addr = a; w.data = dv;
        exp_wr.push_back(w);
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] dv);
        expect_wr(a, dv);
        cpu_req = 1'b1; cpu_wr_en = 1'b1; cpu_addr = a; cpu_dat_in = dv;
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_wr_en = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c0 = done_cnt;
        int n  = 0;
        while (done_cnt == c0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("done_timeout", done_cnt - c0, 1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; cpu_req = 1'b0; cpu_wr_en = 1'b0;
        src_addr = 8'h00; dst_addr = 8'h00; len = 8'h00; fill_val = 8'h00;
        cpu_addr = 8'h00; cpu_dat_in = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_wr_en", int'(mem_wr_en), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // preload source bytes through the CPU path
        cpu_write(8'h10, 8'h11);
        cpu_write(8'h11, 8'h22);
        cpu_write(8'h12, 8'h33);
        cpu_write(8'h13, 8'h44);

        // copy 4 bytes 0x10 -> 0x80: 2*4+1 cycles busy
        expect_wr(8'h80, 8'h11); expect_wr(8'h81, 8'h22);
        expect_wr(8'h82, 8'h33); expect_wr(8'h83, 8'h44);
        go(1'b0, 8'h10, 8'h80, 8'd4, 8'h00, 9, 9);
        wait_done(40);
        cpu_addr = 8'h81;
        @(negedge clk);
        check("cpu_read_0x81", int'(cpu_dat_out), 8'h22);
        @(posedge clk); #1;

        // fill 3 bytes from 0xFE, wrapping to 0x00
        expect_wr(8'hFE, 8'hA5); expect_wr(8'hFF, 8'hA5); expect_wr(8'h00, 8'hA5);
        go(1'b1, 8'h00, 8'hFE, 8'd3, 8'hA5, 4, 4);
        wait_done(40);

        // copy 2 bytes with a 3-cycle CPU write while the engine sits in WR
        expect_wr(8'h40, 8'h77); expect_wr(8'h40, 8'h77); expect_wr(8'h40, 8'h77);
        expect_wr(8'h90, 8'h11); expect_wr(8'h91, 8'h22);
        go(1'b0, 8'h10, 8'h90, 8'd2, 8'h00, 8, 8);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_wr_en = 1'b1; cpu_addr = 8'h40; cpu_dat_in = 8'h77;
        repeat (3) @(posedge clk);
        #1;
        cpu_req = 1'b0; cpu_wr_en = 1'b0;
        wait_done(40);

        // zero-length transfer: done on the very next cycle, no writes
        go(1'b0, 8'h10, 8'hC0, 8'd0, 8'h00, 1, 1);
        wait_done(10);

        // second start while busy must not disturb the running copy
        expect_wr(8'hA0, 8'h11); expect_wr(8'hA1, 8'h22);
        go(1'b0, 8'h10, 8'hA0, 8'd2, 8'h00, 5, 5);
        start = 1'b1; mode = 1'b1; dst_addr = 8'h00; len = 8'd5; fill_val = 8'hEE;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(40);

        // reset after three fill writes aborts with no done pulse
        expect_wr(8'h20, 8'h3C); expect_wr(8'h21, 8'h3C); expect_wr(8'h22, 8'h3C);
        start = 1'b1; mode = 1'b1; dst_addr = 8'h20; len = 8'd8; fill_val = 8'h3C;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        check("mem_80", int'(mem[8'h80]), 8'h11);
        check("mem_83", int'(mem[8'h83]), 8'h44);
        check("mem_FE", int'(mem[8'hFE]), 8'hA5);
        check("mem_FF", int'(mem[8'hFF]), 8'hA5);
        check("mem_00", int'(mem[8'h00]), 8'hA5);
        check("mem_40", int'(mem[8'h40]), 8'h77);
        check("mem_90", int'(mem[8'h90]), 8'h11);
        check("mem_91", int'(mem[8'h91]), 8'h22);
        check("mem_A1", int'(mem[8'hA1]), 8'h22);
        check("mem_C0", int'(mem[8'hC0]), 8'hC0 ^ 8'h5A);
        check("mem_22", int'(mem[8'h22]), 8'h3C);
        check("mem_23", int'(mem[8'h23]), 8'h23 ^ 8'h5A);
        check("pending_writes", exp_wr.size(), 0);
        check("pending_dones", exp_done.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_dma_ctrl.md
MEM_DMA_CTRL -- requirements
Module: mem_dma_ctrl

Interface
REQ-001 The block SHALL have no parameters: data width is 8 bits and address width is 8 bits (256-byte space), both fixed.
REQ-002 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request a transfer; sampled only in IDLE.
REQ-005 mode  input  1  0 = copy, 1 = fill; sampled with start.
REQ-006 src_addr  input  8  copy source base; sampled with start.
REQ-007 dst_addr  input  8  destination base; sampled with start.
REQ-008 len  input  8  byte count, 0..255; sampled with start.
REQ-009 fill_val  input  8  fill byte; sampled with start.
REQ-010 cpu_req  input  1  CPU requests the memory port this cycle.
REQ-011 cpu_wr_en  input  1  CPU write enable, valid with cpu_req.
REQ-012 cpu_addr  input  8  CPU address.
REQ-013 cpu_dat_in  input  8  CPU write data.
REQ-014 cpu_dat_out  output  8  equals mem_dat_out at all times (combinational).
REQ-015 mem_dat_out  input  8  combinational read data from the 256x8 data memory.
REQ-016 mem_wr_en, mem_addr[7:0], mem_dat_in[7:0]  outputs  drive the data memory port.
REQ-017 busy  output  1  high whenever the state is not IDLE.
REQ-018 done  output  1  one-cycle pulse at transfer completion.

Function
REQ-019 The FSM SHALL have states IDLE, RD, WR, FILL and DONE.
REQ-020 IDLE transitions on start=1:
- len=0 -> DONE
- mode=0 -> RD
- mode=1 -> FILL
Start, mode, addresses, len and fill_val SHALL be latched on that edge.
REQ-021 start SHALL be ignored in every state other than IDLE.
REQ-022 Arbitration is fixed priority to the CPU: in any cycle with cpu_req=1, the memory port SHALL be driven as follows, and the engine SHALL hold all of its state (pointers, count, buffer, FSM):
- mem_addr = cpu_addr
- mem_wr_en = cpu_wr_en
- mem_dat_in = cpu_dat_in
REQ-023 RD with cpu_req=0:
- mem_addr = src pointer, mem_wr_en = 0.
- Capture mem_dat_out into an 8-bit buffer at the edge, then go to WR.
REQ-024 WR with cpu_req=0:
- mem_addr = dst pointer, mem_dat_in = buffer, mem_wr_en = 1.
- At the edge, increment both pointers and decrement the remaining count.
- Next state is DONE if remaining was 1, else RD.
REQ-025 FILL with cpu_req=0:
- mem_addr = dst pointer, mem_dat_in = fill_val, mem_wr_en = 1.
- At the edge, increment dst pointer and decrement remaining.
- Next state is DONE if remaining was 1, else FILL.
REQ-026 Pointer increments SHALL wrap modulo 256 (0xFF + 1 = 0x00).
REQ-027 DONE SHALL assert done for exactly one cycle and return to IDLE unconditionally; cpu_req SHALL NOT extend DONE.
REQ-028 When idle, the memory port SHALL be driven as follows:
- In IDLE or DONE with cpu_req=0: mem_wr_en = 0, mem_addr = cpu_addr, mem_dat_in = cpu_dat_in.
REQ-029 Contention-free latency from the start edge to the done pulse:
- copy: 2*len cycles plus 1 DONE cycle.
- fill: len cycles plus 1 DONE cycle.
- len = 0: 1 DONE cycle.
REQ-030 Each stalled cycle (cpu_req=1 while busy, outside DONE) SHALL add exactly one cycle of latency; continuous cpu_req stalls the engine indefinitely, by design.
REQ-031 Overlapping copy SHALL be strictly forward byte-by-byte: when dst > src within the window, already-written bytes propagate. This is defined behaviour.

Reset
REQ-032 When rst_n=0 at posedge clk, the block SHALL:
- go to IDLE
- clear pointers, count and buffer to 0x00
- drive busy = 0 and done = 0
REQ-033 During reset, mem_wr_en SHALL be 0 unless cpu_req=1; memory contents are not cleared.
REQ-034 Reset mid-transfer SHALL abort it with no done pulse; bytes already written SHALL remain.

Verification
REQ-035 Copy: preload mem[0x10..0x13] = 11, 22, 33, 44; start with mode=0, src=0x10, dst=0x80, len=4.
- Required: done pulses 9 cycles after the start edge.
- Required: mem[0x80..0x83] = 11, 22, 33, 44; busy is high for 9 cycles.
REQ-036 Fill with wrap: start with mode=1, dst=0xFE, len=3, fill_val=0xA5.
- Required: mem[0xFE] = mem[0xFF] = mem[0x00] = 0xA5; done pulses 4 cycles after start.
REQ-037 Contention: during a copy of len=2, assert cpu_req with cpu_wr_en=1, cpu_addr=0x40, data 0x77 for 3 cycles while in WR.
- Required: mem[0x40] = 0x77; copy data intact; done delayed by exactly 3 cycles.
REQ-038 len=0 and ignored restart:
- start with len=0 -> done pulses the next cycle with no memory writes.
- start asserted while busy -> no effect on the active transfer.
REQ-039 Reset mid-fill: fill dst=0x20, len=8; drop rst_n after 3 writes.
- Required: mem[0x20..0x22] written, mem[0x23] unchanged, busy = 0 and no done pulse.
